// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch conditioner:
// repeat FSM encoding, 25 MHz board timing defaults and a width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // 25 MHz board clock: 1 ms is about 25000 cycles
    localparam int CLK_HZ             = 25_000_000;
    localparam int CYCLES_PER_MS      = 25_000;
    localparam int DEF_DEBOUNCE_LIMIT = 100_000;
    localparam int DEF_REPEAT_DELAY   = 12_500_000;
    localparam int DEF_REPEAT_PERIOD  = 2_500_000;

    function automatic int clog2_max(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/multi_debounce_if.sv
// Switch-pin and conditioned-output bundle for multi_debounce.
// master drives pins/enables, slave produces levels and pulses.
interface multi_debounce_if #(
    parameter int NUM_SW = 4
);
    logic [NUM_SW-1:0] i_Switches;
    logic [NUM_SW-1:0] i_Repeat_En;
    logic [NUM_SW-1:0] o_Switches;
    logic [NUM_SW-1:0] o_Press;
    logic [NUM_SW-1:0] o_Release;
    logic [NUM_SW-1:0] o_Event;

    modport master (
        output i_Switches,
        output i_Repeat_En,
        input  o_Switches,
        input  o_Press,
        input  o_Release,
        input  o_Event
    );

    modport slave (
        input  i_Switches,
        input  i_Repeat_En,
        output o_Switches,
        output o_Press,
        output o_Release,
        output o_Event
    );

endinterface

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, debounce counter and
// hold-to-repeat FSM, all outputs registered.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Pin,
    input  logic i_Repeat_En,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Event
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
    localparam int RP_W = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [RP_W-1:0] DLY_MAX = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_MAX = RP_W'(REPEAT_PERIOD - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            r_release;
    logic            r_event;
    rep_state_t      r_rep_state;
    logic [RP_W-1:0] r_rep_cnt;

    logic            w_mismatch;
    logic            w_flip;
    logic            w_rise;
    logic            w_fall;
    logic            w_tick;
    logic [DB_W-1:0] w_db_cnt_nxt;
    rep_state_t      w_rep_nxt;
    logic [RP_W-1:0] w_rep_cnt_nxt;

    assign w_mismatch = (r_sync != r_state);
    assign w_flip     = w_mismatch && (r_db_cnt == DB_MAX);
    assign w_rise     = w_flip && !r_state;
    assign w_fall     = w_flip && r_state;

    // any matching sample restarts the count, so glitches leave no trace
    always_comb begin
        w_db_cnt_nxt = '0;
        if (w_mismatch && !w_flip) begin
            w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rep_nxt     = r_rep_state;
        w_rep_cnt_nxt = r_rep_cnt;
        w_tick        = 1'b0;
        unique case (r_rep_state)
            IDLE: begin
                if (w_rise && i_Repeat_En) begin
                    w_rep_nxt     = DELAY;
                    w_rep_cnt_nxt = '0;
                end
            end
            DELAY: begin
                if (w_fall || !i_Repeat_En) begin
                    w_rep_nxt     = IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (r_rep_cnt == DLY_MAX) begin
                    w_tick        = 1'b1;
                    w_rep_nxt     = REPEAT;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                end
            end
            REPEAT: begin
                // a release on the tick edge suppresses that tick
                if (w_fall || !i_Repeat_En) begin
                    w_rep_nxt     = IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (r_rep_cnt == PER_MAX) begin
                    w_tick        = 1'b1;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                end
            end
            default: begin
                w_rep_nxt     = IDLE;
                w_rep_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_meta      <= 1'b0;
            r_sync      <= 1'b0;
            r_state     <= 1'b0;
            r_db_cnt    <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_event     <= 1'b0;
            r_rep_state <= IDLE;
            r_rep_cnt   <= '0;
        end else begin
            r_meta      <= i_Pin;
            r_sync      <= r_meta;
            r_state     <= r_state ^ w_flip;
            r_db_cnt    <= w_db_cnt_nxt;
            r_press     <= w_rise;
            r_release   <= w_fall;
            r_event     <= w_rise || w_tick;
            r_rep_state <= w_rep_nxt;
            r_rep_cnt   <= w_rep_cnt_nxt;
        end
    end

    assign o_Level   = r_state;
    assign o_Press   = r_press;
    assign o_Release = r_release;
    assign o_Event   = r_event;

endmodule

// File: rtl/multi_debounce.sv
// N independent switch conditioners; each bit slice of the bus
// is handled by its own debounce_channel.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    multi_debounce_if.slave bus
);

    logic [NUM_SW-1:0] w_level;
    logic [NUM_SW-1:0] w_press;
    logic [NUM_SW-1:0] w_release;
    logic [NUM_SW-1:0] w_event;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .i_Clk       (i_Clk),
            .i_Rst       (i_Rst),
            .i_Pin       (bus.i_Switches[g]),
            .i_Repeat_En (bus.i_Repeat_En[g]),
            .o_Level     (w_level[g]),
            .o_Press     (w_press[g]),
            .o_Release   (w_release[g]),
            .o_Event     (w_event[g])
        );
    end

    assign bus.o_Switches = w_level;
    assign bus.o_Press    = w_press;
    assign bus.o_Release  = w_release;
    assign bus.o_Event    = w_event;

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed scenarios with literal expectations
// plus randomized pins checked every cycle against a behavioural model.
module tb_multi_debounce;

    localparam int NSW = 2;
    localparam int DBL = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic clk;
    logic rst;

    multi_debounce_if #(.NUM_SW(NSW)) bus ();

    multi_debounce #(
        .NUM_SW         (NSW),
        .DEBOUNCE_LIMIT (DBL),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the synchronised pin is the pin seen two edges
    // earlier; a level is accepted after DBL consecutive differing samples.
    // Repeat events are timed by the age of the press.
    bit          m_started = 0;
    bit          m_s1 [NSW];
    bit          m_s2 [NSW];
    bit          m_lvl[NSW];
    int          m_run[NSW];
    bit          m_act[NSW];
    int          m_age[NSW];
    logic [NSW-1:0] e_sw, e_press, e_rel, e_ev;

    initial begin
        forever begin
            @(posedge clk);
            for (int c = 0; c < NSW; c++) begin
                bit s;
                if (rst) begin
                    m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
                    m_run[c] = 0; m_act[c] = 0; m_age[c] = 0;
                    e_sw[c] = 0; e_press[c] = 0;
                    e_rel[c] = 0; e_ev[c] = 0;
                end else begin
                    s = m_s2[c];
                    m_s2[c] = m_s1[c];
                    m_s1[c] = bus.i_Switches[c];
                    e_press[c] = 0; e_rel[c] = 0; e_ev[c] = 0;
                    if (s != m_lvl[c]) m_run[c]++;
                    else m_run[c] = 0;
                    if (m_run[c] == DBL) begin
                        m_lvl[c] = !m_lvl[c];
                        m_run[c] = 0;
                        if (m_lvl[c]) e_press[c] = 1;
                        else e_rel[c] = 1;
                    end
                    if (m_act[c]) begin
                        if (e_rel[c] || !bus.i_Repeat_En[c]) begin
                            m_act[c] = 0;
                        end else begin
                            m_age[c]++;
                            if (m_age[c] == RD ||
                                (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
                                e_ev[c] = 1;
                        end
                    end
                    if (e_press[c]) begin
                        e_ev[c] = 1;
                        if (bus.i_Repeat_En[c]) begin
                            m_act[c] = 1;
                            m_age[c] = 0;
                        end
                    end
                    e_sw[c] = m_lvl[c];
                end
            end
            if (rst) m_started = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("model_sw",  bus.o_Switches, e_sw);
                chk("model_prs", bus.o_Press,    e_press);
                chk("model_rel", bus.o_Release,  e_rel);
                chk("model_evt", bus.o_Event,    e_ev);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pat;
        logic       anyp;
        int         nev;

        rst = 1'b1;
        bus.i_Switches  = '0;
        bus.i_Repeat_En = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_sw",  bus.o_Switches, 2'b00);
        chk("rst_evt", bus.o_Event,    2'b00);
        rst = 1'b0;
        repeat (3) step();

        // bounce on ch0: no run of 4 equal samples
        pat  = 7'b1110110;
        anyp = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            bus.i_Switches[0] = pat[i];
            step();
            anyp = anyp | bus.o_Press[0] | bus.o_Event[0];
        end
        bus.i_Switches[0] = 1'b0;
        repeat (8) begin
            step();
            anyp = anyp | bus.o_Press[0] | bus.o_Event[0];
        end
        chk("bounce_sw",    {1'b0, bus.o_Switches[0]}, 2'b00);
        chk("bounce_pulse", {1'b0, anyp},              2'b00);

        // clean press on ch0, repeat disabled
        bus.i_Switches[0] = 1'b1;
        repeat (5) step();
        chk("press_e5_sw", {1'b0, bus.o_Switches[0]}, 2'b00);
        step();
        chk("press_e6_sw",  {1'b0, bus.o_Switches[0]}, 2'b01);
        chk("press_e6_prs", {1'b0, bus.o_Press[0]},    2'b01);
        chk("press_e6_evt", {1'b0, bus.o_Event[0]},    2'b01);
        step();
        chk("press_e7_prs", {1'b0, bus.o_Press[0]}, 2'b00);
        nev = 0;
        repeat (33) begin
            step();
            nev += int'(bus.o_Event[0]);
        end
        chk("hold_noevt", (nev == 0) ? 2'b01 : 2'b00, 2'b01);
        bus.i_Switches[0] = 1'b0;
        repeat (5) step();
        chk("rel_e5_sw", {1'b0, bus.o_Switches[0]}, 2'b01);
        step();
        chk("rel_e6_sw",  {1'b0, bus.o_Switches[0]}, 2'b00);
        chk("rel_e6_rel", {1'b0, bus.o_Release[0]},  2'b01);
        chk("rel_e6_evt", {1'b0, bus.o_Event[0]},    2'b00);
        step();
        chk("rel_e7_rel", {1'b0, bus.o_Release[0]}, 2'b00);
        repeat (3) step();

        // repeat on ch1; release lands on the P+19 tick edge
        bus.i_Repeat_En[1] = 1'b1;
        bus.i_Switches[1]  = 1'b1;
        repeat (6) step();
        chk("rep_P_prs", {1'b0, bus.o_Press[1]}, 2'b01);
        chk("rep_P_evt", {1'b0, bus.o_Event[1]}, 2'b01);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 18)
                chk($sformatf("rep_P+%0d_evt", k), {1'b0, bus.o_Event[1]},
                    {1'b0, (k == 10 || k == 13 || k == 16)});
            if (k == 13) bus.i_Switches[1] = 1'b0;
            if (k == 19) begin
                chk("rep_P+19_rel", {1'b0, bus.o_Release[1]}, 2'b01);
                chk("rep_P+19_evt", {1'b0, bus.o_Event[1]},   2'b00);
            end
            if (k == 20)
                chk("rep_P+20_evt", {1'b0, bus.o_Event[1]}, 2'b00);
        end
        repeat (4) step();

        // enable dropped mid-hold: only the P+10 tick survives
        bus.i_Switches[1] = 1'b1;
        repeat (6) step();
        chk("en_P_prs", {1'b0, bus.o_Press[1]}, 2'b01);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk($sformatf("en_P+%0d_evt", k), {1'b0, bus.o_Event[1]},
                {1'b0, (k == 10)});
            if (k == 11) bus.i_Repeat_En[1] = 1'b0;
        end
        bus.i_Switches[1]  = 1'b0;
        bus.i_Repeat_En[1] = 1'b1;
        repeat (8) step();

        // reset during ch1 REPEAT and ch0 count=2
        bus.i_Switches[1] = 1'b1;
        repeat (17) step();
        bus.i_Switches[0] = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("rstmid_sw",  bus.o_Switches, 2'b00);
        chk("rstmid_prs", bus.o_Press,    2'b00);
        chk("rstmid_rel", bus.o_Release,  2'b00);
        chk("rstmid_evt", bus.o_Event,    2'b00);
        rst = 1'b0;
        repeat (5) step();
        chk("rst_e5_sw", bus.o_Switches, 2'b00);
        step();
        chk("rst_e6_sw",  bus.o_Switches, 2'b11);
        chk("rst_e6_prs", bus.o_Press,    2'b11);
        chk("rst_e6_evt", bus.o_Event,    2'b11);
        bus.i_Switches = 2'b00;
        repeat (10) step();

        // independence: ch1 pressed two cycles after ch0
        bus.i_Switches[0] = 1'b1;
        step();
        step();
        bus.i_Switches[1] = 1'b1;
        repeat (4) step();
        chk("ind_e6_prs", bus.o_Press,    2'b01);
        chk("ind_e6_sw",  bus.o_Switches, 2'b01);
        step();
        step();
        chk("ind_e8_prs", bus.o_Press,    2'b10);
        chk("ind_e8_sw",  bus.o_Switches, 2'b11);
        bus.i_Switches = 2'b00;
        repeat (10) step();

        // randomized: alternate noisy and calm phases
        for (int i = 0; i < 4000; i++) begin
            int lim;
            lim = ((i / 200) % 2 == 0) ? 2 : 30;
            for (int c = 0; c < NSW; c++) begin
                if ($urandom_range(0, lim) == 0)
                    bus.i_Switches[c] = !bus.i_Switches[c];
                if ($urandom_range(0, 60) == 0)
                    bus.i_Repeat_En[c] = !bus.i_Repeat_En[c];
            end
            rst = ($urandom_range(0, 700) == 0);
            step();
        end
        rst = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
